// File: rtl/video_frame_packer.sv
// Packs RGB565 or paired 8-bit grey pixels into 20-bit words with frame decimation; words leave 2 cycles after the
// pixel is sampled, out_ready is never waited on (a refused word is dropped and flagged). VFP_FRAME_STATS_EN enables frame_cnt.
module video_frame_packer #(
  parameter int SKIP_W = 4,
  parameter int X_W    = 11,
  parameter int COEF_R = 76,
  parameter int COEF_G = 75,
  parameter int COEF_B = 29
) (
  input  logic              video_clk,
  input  logic              rst,
  input  logic              cfg_grey,
  input  logic [SKIP_W-1:0] cfg_skip,
  input  logic              in_vs,
  input  logic              in_de,
  input  logic [15:0]       in_data,
  input  logic              out_ready,
  output logic              out_valid,
  output logic [19:0]       out_data,
  output logic              out_sof,
  output logic              overflow,
  output logic [15:0]       frame_cnt
);

  typedef enum logic [1:0] {IDLE = 2'd0, SKIP = 2'd1, ACTIVE = 2'd2} state_e;

  localparam logic [SKIP_W-1:0] SKIP_ONE = 1;
  localparam logic [X_W-1:0]    X_ONE    = 1;

  state_e            state_q, state_d;
  logic              vs1_q, vs2_q, vs3_q;
  logic              de1_q, de2_q, de3_q;
  logic [15:0]       d1_q, d2_q;
  logic              grey_q;
  logic [SKIP_W-1:0] skip_cnt_q, skip_cnt_d;
  logic [X_W-1:0]    x_q, x_d;
  logic [7:0]        hold_q, hold_d;
  logic              valid_d, sof_d;
  logic [19:0]       data_d;
  logic              out_valid_q, out_sof_q, ovf_q;
  logic [19:0]       out_data_q;
  logic              frame_start, de_fall;
  logic [12:0]       y_full;
  logic [7:0]        y;

  function automatic logic [19:0] pack_word(input logic sof, input logic [7:0] hi, input logic [7:0] lo);
    return {1'b1, sof, hi, 1'b1, sof, lo};
  endfunction

  assign frame_start = vs3_q & ~vs2_q;
  assign de_fall     = de3_q & ~de2_q;
  assign skip_cnt_d  = (skip_cnt_q >= cfg_skip) ? '0 : skip_cnt_q + SKIP_ONE;

  assign y_full = 13'(d2_q[15:11]) * 13'(COEF_R) + 13'(d2_q[10:5]) * 13'(COEF_G) + 13'(d2_q[4:0]) * 13'(COEF_B);
  assign y      = 8'(y_full >> 5);

  always_ff @(posedge video_clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // The pre-increment skip count decides whether the new frame is kept.
  always_comb begin
    state_d = state_q;
    if (frame_start) begin
      state_d = (skip_cnt_q == '0) ? ACTIVE : SKIP;
    end
  end

  always_comb begin
    valid_d = 1'b0;
    sof_d   = 1'b0;
    data_d  = '0;
    x_d     = x_q;
    hold_d  = hold_q;
    if (de_fall) begin
      x_d = '0;
    end
    if (frame_start) begin
      if (skip_cnt_q == '0) begin
        valid_d = 1'b1;
        sof_d   = 1'b1;
        data_d  = pack_word(1'b1, 8'h00, 8'h00);
      end
    end else if (state_q == ACTIVE) begin
      if (de2_q) begin
        x_d = (&x_q) ? x_q : x_q + X_ONE;
        if (!grey_q) begin
          valid_d = 1'b1;
          data_d  = pack_word(1'b0, d2_q[15:8], d2_q[7:0]);
        end else if (!x_q[0]) begin
          hold_d = y;
        end else begin
          valid_d = 1'b1;
          data_d  = pack_word(1'b0, hold_q, y);
        end
      end else if (de_fall && grey_q && x_q[0]) begin
        // Line ended with an unpaired grey pixel: flush it with a zero pad byte.
        valid_d = 1'b1;
        data_d  = pack_word(1'b0, hold_q, 8'h00);
      end
    end
  end

  always_ff @(posedge video_clk) begin
    if (rst) begin
      vs1_q       <= 1'b0;
      vs2_q       <= 1'b0;
      vs3_q       <= 1'b0;
      de1_q       <= 1'b0;
      de2_q       <= 1'b0;
      de3_q       <= 1'b0;
      d1_q        <= '0;
      d2_q        <= '0;
      grey_q      <= 1'b0;
      skip_cnt_q  <= '0;
      x_q         <= '0;
      hold_q      <= '0;
      out_valid_q <= 1'b0;
      out_sof_q   <= 1'b0;
      out_data_q  <= '0;
      ovf_q       <= 1'b0;
    end else begin
      vs1_q       <= in_vs;
      vs2_q       <= vs1_q;
      vs3_q       <= vs2_q;
      de1_q       <= in_de;
      de2_q       <= de1_q;
      de3_q       <= de2_q;
      d1_q        <= in_data;
      d2_q        <= d1_q;
      if (frame_start) begin
        grey_q     <= cfg_grey;
        skip_cnt_q <= skip_cnt_d;
      end
      x_q         <= x_d;
      hold_q      <= hold_d;
      out_valid_q <= valid_d;
      out_sof_q   <= sof_d;
      out_data_q  <= data_d;
      ovf_q       <= ovf_q | (out_valid_q & ~out_ready);
    end
  end

  assign out_valid = out_valid_q;
  assign out_sof   = out_sof_q;
  assign out_data  = out_data_q;
  assign overflow  = ovf_q;

`ifdef VFP_FRAME_STATS_EN
  logic [15:0] frame_cnt_q;

  always_ff @(posedge video_clk) begin
    if (rst) begin
      frame_cnt_q <= '0;
    end else if (sof_d) begin
      frame_cnt_q <= frame_cnt_q + 16'd1;
    end
  end

  assign frame_cnt = frame_cnt_q;
`else
  assign frame_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_video_frame_packer.sv
// Scoreboard bench for video_frame_packer: stimulus pushes expected words, a monitor pops and compares them.
module tb_video_frame_packer;

  logic        video_clk = 1'b0;
  logic        rst;
  logic        cfg_grey;
  logic [3:0]  cfg_skip;
  logic        in_vs;
  logic        in_de;
  logic [15:0] in_data;
  logic        out_ready;
  logic        out_valid;
  logic [19:0] out_data;
  logic        out_sof;
  logic        overflow;
  logic [15:0] frame_cnt;

  video_frame_packer dut (
    .video_clk (video_clk),
    .rst       (rst),
    .cfg_grey  (cfg_grey),
    .cfg_skip  (cfg_skip),
    .in_vs     (in_vs),
    .in_de     (in_de),
    .in_data   (in_data),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_sof   (out_sof),
    .overflow  (overflow),
    .frame_cnt (frame_cnt)
  );

  always #5 video_clk = ~video_clk;

  typedef struct {
    logic [19:0] w;
    int          c;
  } exp_t;

  exp_t        exp_q[$];
  logic [15:0] px_q[$];
  int cyc = 0;
  int checks = 0;
  int passed = 0;
  int drops = 0;
  int sof_seen = 0;
  int frame_idx = 0;
  int sofs = 0;

  function automatic logic [19:0] pack(input logic s, input logic [7:0] hi, input logic [7:0] lo);
    return {1'b1, s, hi, 1'b1, s, lo};
  endfunction

  function automatic logic [7:0] grey_of(input logic [15:0] p);
    int yv;
    yv = int'(p[15:11]) * 76 + int'(p[10:5]) * 75 + int'(p[4:0]) * 29;
    return 8'(yv / 32);
  endfunction

  function automatic int exp_fc();
`ifdef VFP_FRAME_STATS_EN
    return sofs % 65536;
`else
    return 0;
`endif
  endfunction

  function automatic void push(input logic [19:0] w);
    exp_t e;
    e.w = w;
    e.c = cyc;
    exp_q.push_back(e);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act === req) passed++;
    else $display("FAIL %s: got %0h, want %0h", name, act, req);
  endtask

  initial forever begin
    @(posedge video_clk);
    cyc++;
  end

  // Monitor: every presented word is popped, including words refused by out_ready.
  initial forever begin
    exp_t e;
    @(negedge video_clk);
    #1;
    if (out_valid === 1'b1) begin
      if (out_sof === 1'b1) sof_seen++;
      if (out_ready !== 1'b1) drops++;
      if (exp_q.size() == 0) begin
        checks++;
        $display("FAIL unexpected_word: got %0h, want no word", out_data);
      end else begin
        e = exp_q.pop_front();
        check("word", {11'b0, out_sof, out_data}, {11'b0, e.w[18], e.w});
        check("latency", 32'(cyc - e.c), 32'd3);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish, want finish");
    $fatal(1, "timeout");
  end

  task automatic drain();
    repeat (6) @(negedge video_clk);
    check("drained", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge video_clk);
    rst = 1'b0;
    exp_q.delete();
    frame_idx = 0;
    sofs = 0;
  endtask

  task automatic send_line(input bit g, input bit kept, input bit discard_first, input bit bp);
    int n = 0;
    logic [7:0] hold = 8'h00;
    for (int i = 0; i < px_q.size(); i++) begin
      in_de = 1'b1;
      in_data = px_q[i];
      out_ready = !(bp && i == px_q.size() / 2);
      if (kept && !(discard_first && i == 0)) begin
        if (!g) push(pack(1'b0, px_q[i][15:8], px_q[i][7:0]));
        else begin
          if (n % 2 == 0) hold = grey_of(px_q[i]);
          else push(pack(1'b0, hold, grey_of(px_q[i])));
          n++;
        end
      end
      @(negedge video_clk);
    end
    in_de = 1'b0;
    out_ready = 1'b1;
    if (kept && g && (n % 2 == 1)) push(pack(1'b0, hold, 8'h00));
    repeat (3) @(negedge video_clk);
  endtask

  task automatic run_frame(input bit g, input int nlines, input bit collide, input bit bp, input bit directed);
    bit kept;
    cfg_grey = g;
    in_vs = 1'b1;
    in_de = 1'b0;
    repeat (3) @(negedge video_clk);
    kept = (frame_idx % (int'(cfg_skip) + 1)) == 0;
    frame_idx++;
    in_vs = 1'b0;
    if (kept) begin
      push(pack(1'b1, 8'h00, 8'h00));
      sofs++;
    end
    if (!collide) repeat (3) @(negedge video_clk);
    for (int l = 0; l < nlines; l++) begin
      if (!directed) begin
        px_q.delete();
        for (int k = 0; k < int'($urandom_range(1, 9)); k++) px_q.push_back(16'($urandom));
      end
      send_line(g, kept, collide && l == 0, bp && l == 0);
      // Mid-frame format change must not affect this frame.
      cfg_grey = ~g;
    end
  endtask

  initial begin
    int s0;
    int d0;
    rst = 1'b1;
    cfg_grey = 1'b0;
    cfg_skip = 4'd0;
    in_vs = 1'b0;
    in_de = 1'b0;
    in_data = 16'h0000;
    out_ready = 1'b1;
    repeat (3) @(negedge video_clk);
    rst = 1'b0;
    check("rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("rst_out_sof", {31'b0, out_sof}, 32'd0);
    check("rst_out_data", {12'b0, out_data}, 32'd0);
    check("rst_overflow", {31'b0, overflow}, 32'd0);
    check("rst_frame_cnt", {16'b0, frame_cnt}, 32'd0);

    px_q = '{16'h1234, 16'h1235, 16'h1236, 16'h1237};
    run_frame(1'b0, 1, 1'b0, 1'b0, 1'b1);
    px_q = '{16'hFFFF, 16'h0000, 16'hFFFF};
    run_frame(1'b1, 1, 1'b0, 1'b0, 1'b1);
    drain();
    check("frame_cnt_directed", {16'b0, frame_cnt}, 32'(exp_fc()));

    cfg_skip = 4'd2;
    do_reset();
    s0 = sof_seen;
    repeat (6) run_frame(1'($urandom), 1, 1'b0, 1'b0, 1'b0);
    drain();
    check("skip_sof_count", 32'(sof_seen - s0), 32'd2);
    check("frame_cnt_skip", {16'b0, frame_cnt}, 32'(exp_fc()));

    cfg_skip = 4'd0;
    do_reset();
    d0 = drops;
    px_q.delete();
    for (int k = 0; k < 10; k++) px_q.push_back(16'($urandom));
    run_frame(1'b0, 1, 1'b0, 1'b1, 1'b1);
    drain();
    check("bp_drops", 32'(drops - d0), 32'd1);
    check("bp_overflow", {31'b0, overflow}, 32'd1);
    run_frame(1'b1, 2, 1'b0, 1'b0, 1'b0);
    drain();
    check("bp_overflow_sticky", {31'b0, overflow}, 32'd1);
    do_reset();
    check("bp_overflow_cleared", {31'b0, overflow}, 32'd0);

    px_q.delete();
    for (int k = 0; k < 5; k++) px_q.push_back(16'($urandom));
    run_frame(1'b0, 1, 1'b1, 1'b0, 1'b1);
    drain();

    cfg_skip = 4'd2;
    cfg_grey = 1'b0;
    in_vs = 1'b1;
    repeat (3) @(negedge video_clk);
    in_vs = 1'b0;
    push(pack(1'b1, 8'h00, 8'h00));
    frame_idx++;
    sofs++;
    repeat (3) @(negedge video_clk);
    for (int i = 0; i < 8; i++) begin
      in_de = 1'b1;
      in_data = 16'($urandom);
      if (i < 4) push(pack(1'b0, in_data[15:8], in_data[7:0]));
      rst = (i == 4);
      @(negedge video_clk);
      if (i == 4) begin
        exp_q.delete();
        frame_idx = 0;
        sofs = 0;
        check("rst_midline_valid", {31'b0, out_valid}, 32'd0);
      end
    end
    in_de = 1'b0;
    repeat (4) @(negedge video_clk);
    run_frame(1'($urandom), 2, 1'b0, 1'b0, 1'b0);
    drain();
    check("frame_cnt_after_rst", {16'b0, frame_cnt}, 32'(exp_fc()));

    for (int seg = 0; seg < 3; seg++) begin
      cfg_skip = 4'($urandom_range(0, 3));
      do_reset();
      repeat (8) run_frame(1'($urandom), int'($urandom_range(1, 3)), 1'b0, 1'b0, 1'b0);
      drain();
      check("frame_cnt_random", {16'b0, frame_cnt}, 32'(exp_fc()));
      check("overflow_random", {31'b0, overflow}, 32'd0);
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
